// File: rtl/tone_pkg.sv
// Shared types and constants for the tone_player note engine.
// The GAP state is only reachable in builds with TONE_GAP_EN defined.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int unsigned TICKS_PER_MS(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

  // Half-period counts at 100 MHz; C4..F4 need more than 17 bits of half-period.
  localparam int unsigned HALF_C4 = 191110;
  localparam int unsigned HALF_D4 = 170265;
  localparam int unsigned HALF_E4 = 151685;
  localparam int unsigned HALF_F4 = 143172;
  localparam int unsigned HALF_G4 = 127551;
  localparam int unsigned HALF_A4 = 113636;
  localparam int unsigned HALF_B4 = 101239;
  localparam int unsigned HALF_C5 = 95556;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICKS-1 and flags the wrap cycle on tick_c.
// Synchronous clear holds the count at zero and suppresses the tick.
module ms_tick_gen
  import tone_pkg::*;
#(
  parameter int unsigned TICKS = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_c = !clr && (cnt_q == CNT_W'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Square-wave note player with valid/ready note input and PmodAMP2 control pins.
// Define TONE_GAP_EN to insert GAP_MS of silence after every note.
module tone_player
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned HALF_W = 17,
  parameter int unsigned DUR_W  = 10,
  parameter int unsigned GAP_MS = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              gain_hi,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [HALF_W-1:0] note_half,
  input  logic [DUR_W-1:0]  note_dur_ms,
  output logic              busy,
  output logic              audio_out,
  output logic              amp_gain,
  output logic              amp_shdn
);

  localparam int unsigned TICKS = TICKS_PER_MS(CLK_HZ);

  if ((CLK_HZ % 1000) != 0 || TICKS == 0) begin : g_bad_clk
    $error("tone_player: CLK_HZ must be a nonzero multiple of 1000");
  end
  if (GAP_MS == 0) begin : g_bad_gap
    $error("tone_player: GAP_MS must be at least 1");
  end

  state_e            state_q, state_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] hcnt_q, hcnt_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  ms_q, ms_d;
  logic              audio_q, audio_d;
  logic              busy_q, busy_d;
  logic              accept_c;
  logic              tick_c;
  logic              play_done_c;
  logic              gap_done_c;

`ifdef TONE_GAP_EN
  localparam int unsigned GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  logic [GAP_W-1:0] gap_q, gap_d;
  assign gap_done_c = (state_q == GAP) && tick_c && (gap_q == GAP_W'(GAP_MS - 1));
`else
  assign gap_done_c = 1'b0;
`endif

  assign note_ready  = (state_q == IDLE) && enable;
  assign accept_c    = note_valid && note_ready;
  assign play_done_c = (state_q == PLAY) && tick_c && (ms_q == dur_q - DUR_W'(1));
  assign amp_gain    = gain_hi;
  assign amp_shdn    = enable;
  assign busy        = busy_q;
  assign audio_out   = audio_q;

  // Prescaler only runs while a note or gap is active.
  ms_tick_gen #(.TICKS(TICKS)) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    ((state_q == IDLE) || !enable),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept_c && (note_dur_ms != '0)) state_d = PLAY;
        PLAY: begin
          if (play_done_c) begin
`ifdef TONE_GAP_EN
            state_d = GAP;
`else
            state_d = IDLE;
`endif
          end
        end
        default: if (gap_done_c || (state_q != GAP)) state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    half_d  = half_q;
    dur_d   = dur_q;
    hcnt_d  = hcnt_q;
    ms_d    = ms_q;
    audio_d = audio_q;
    busy_d  = (state_d != IDLE);
`ifdef TONE_GAP_EN
    gap_d   = gap_q;
`endif
    if (!enable) begin
      hcnt_d  = '0;
      ms_d    = '0;
      audio_d = 1'b0;
`ifdef TONE_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          audio_d = 1'b0;
          if (accept_c) begin
            half_d = note_half;
            dur_d  = note_dur_ms;
            hcnt_d = '0;
            ms_d   = '0;
          end
        end
        PLAY: begin
          // A zero half-period is a rest: hold the line low.
          if (half_q == '0) begin
            hcnt_d  = '0;
            audio_d = 1'b0;
          end else if (hcnt_q == half_q - HALF_W'(1)) begin
            hcnt_d  = '0;
            audio_d = ~audio_q;
          end else begin
            hcnt_d = hcnt_q + HALF_W'(1);
          end
          if (tick_c) ms_d = ms_q + DUR_W'(1);
          if (play_done_c) begin
            hcnt_d  = '0;
            ms_d    = '0;
            audio_d = 1'b0;
          end
        end
        default: begin
          audio_d = 1'b0;
`ifdef TONE_GAP_EN
          if (gap_done_c) begin
            gap_d = '0;
          end else if (tick_c) begin
            gap_d = gap_q + GAP_W'(1);
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= '0;
      dur_q   <= '0;
      hcnt_q  <= '0;
      ms_q    <= '0;
      audio_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TONE_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      half_q  <= half_d;
      dur_q   <= dur_d;
      hcnt_q  <= hcnt_d;
      ms_q    <= ms_d;
      audio_q <= audio_d;
      busy_q  <= busy_d;
`ifdef TONE_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: doc/tone_player.md
# tone_player

Parametrised successor to the fixed 440 Hz switch-gated square-wave generator. It accepts notes over a valid/ready handshake and plays each one for a programmed duration. A note is a half-period count (0 means rest) and a duration in milliseconds. The output is a square wave on `audio_out`, and the block also drives the PmodAMP2 gain and shutdown pins. It sits between a note source (ROM sequencer or FSM) and the amplifier header JA.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency; must be a multiple of 1000.
- `HALF_W`, 17, width of the half-period field. A4 is 113636 cycles at 100 MHz.
- `DUR_W`, 10, width of the duration field in ms (max 1023 ms).
- `GAP_MS`, 20, length of the silent gap after each note, in ms (used only with `TONE_GAP_EN`).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: master on/off (the board switch); must be synchronous to `clk`.
- `gain_hi` in 1: amplifier gain select.
- `note_valid` in 1: note request.
- `note_ready` out 1: block can accept a note.
- `note_half` in `HALF_W`: half-period in clk cycles; 0 means rest.
- `note_dur_ms` in `DUR_W`: note duration in ms.
- `busy` out 1: a note or gap is in progress.
- `audio_out` out 1: square-wave audio.
- `amp_gain` out 1: PmodAMP2 GAIN pin.
- `amp_shdn` out 1: PmodAMP2 SHDN pin (1 = amplifier on).

## Operation
- FSM states are IDLE, PLAY and GAP.
- Reset values: state IDLE, `audio_out` 0, `busy` 0, all counters 0.
- `note_ready` = (state == IDLE) && `enable`, combinational. A note is accepted on a clk edge where `note_valid` && `note_ready`.
- Accept in IDLE:
  - Latch `note_half` and `note_dur_ms`.
  - Clear the half-period counter, the ms prescaler and the ms counter.
  - If `note_dur_ms` == 0, stay in IDLE; the note is consumed as a no-op.
  - Otherwise go to PLAY.
- PLAY:
  - The half-period counter runs 0..half-1 and wraps. `audio_out` toggles on each wrap.
  - half == 1 toggles every cycle. half == 0 holds `audio_out` at 0 (rest).
  - The ms prescaler wraps at CLK_HZ/1000 − 1 and emits a 1-cycle tick.
  - The ms counter increments on each tick. On the tick that makes it equal to the latched duration:
    - `audio_out` is forced to 0.
    - Next state is GAP (with `TONE_GAP_EN`) or IDLE (without).
- GAP: `audio_out` stays 0. After GAP_MS ticks the block returns to IDLE.
- `enable` deasserted in any state: next edge forces IDLE, `audio_out` 0 and counters cleared. The note in progress is dropped, not resumed.
- Other outputs:
  - `busy` = (state != IDLE), registered with the state.
  - `amp_gain` = `gain_hi`, passed straight through.
  - `amp_shdn` = `enable`.
- Counters are unsigned. The half-period counter is `HALF_W` bits wide and never exceeds half−1.

## Timing
- Accept at edge k:
  - PLAY and `busy` are visible after k.
  - First rise of `audio_out` is at edge k + half.
- PLAY lasts exactly dur × CLK_HZ/1000 cycles, then GAP lasts GAP_MS × CLK_HZ/1000 cycles.
- `note_ready` rises in the first IDLE cycle. Back-to-back notes have no extra bubble beyond that cycle.
- Output period is exactly 2 × half cycles. The last half-cycle is truncated when the duration ends.

## Configuration
- `TONE_GAP_EN` defined: the GAP state exists and notes are separated by GAP_MS ms of silence. This articulates repeated identical notes.
- `TONE_GAP_EN` undefined: PLAY → IDLE directly, and the GAP state and its counter are not synthesised.

## Structure
- Package `tone_pkg` holds:
  - the state enum (IDLE/PLAY/GAP);
  - the `TICKS_PER_MS(CLK_HZ)` constant function;
  - named half-period constants for C4..C5 at 100 MHz (e.g. A4 = 113636, C5 = 95556).
- Sub-module `ms_tick_gen`: ms prescaler with synchronous clear and a 1-cycle tick output.

## Test plan
Benches run with CLK_HZ = 10_000 (10 cycles/ms) and GAP_MS = 2.
- Reset mid-PLAY (`rst_n` low for 3 cycles) → `audio_out` 0, `busy` 0 and `note_ready` 1 immediately; no toggles after release.
- Note half = 3, dur = 2 → `audio_out` period 6 cycles, toggles at k+3, k+6, …; PLAY lasts 20 cycles; with the gap, `note_ready` returns 20 + 20 + 1 cycles after accept.
- Rest (half = 0, dur = 1) → `audio_out` stays 0 for 10 cycles, `busy` is 1 throughout.
- dur = 0 with `note_valid` held → no PLAY entry, `busy` stays 0, the note is consumed and `note_ready` remains 1.
- `enable` dropped at cycle 5 of PLAY → IDLE next edge, `audio_out` 0, `amp_shdn` 0, `note_ready` 0 until `enable` returns.
- Two queued notes (half = 2 then 4) with `TONE_GAP_EN` off → the second note starts one cycle after the first ends; periods 4 then 8.
